// File: rtl/misc_v_pkg.sv
// Shared constants and types for the operand stage of the 16-bit, 8-register core.
//   DATA_W / REG_ADDR_W / CTRL_W / CNT_W : default widths for data, register address,
//                                          decoded control bundle and stall counter
//   NUM_REGS, ZERO_REG                   : register file size and the hard-wired zero register
//   NUM_SRC                              : source operands per instruction
//   op_state_e                           : occupancy of the operand pipeline register
package misc_v_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned CTRL_W     = 8;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned ZERO_REG   = 0;
    localparam int unsigned NUM_SRC    = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } op_state_e;

endpackage : misc_v_pkg

// File: rtl/operand_forward_mux.sv
// Resolves one source operand from register-file data and the EX/MEM forwarding paths.
//   addr_i                     : source register address
//   reg_data_i                 : register file read data for addr_i
//   ex_fwd_valid_i/_rd_i/_data_i, ex_is_load_i : EX-stage result and whether it is a pending load
//   mem_fwd_valid_i/_rd_i/_data_i              : MEM-stage result
//   operand_c_o                : resolved operand (combinational)
module operand_forward_mux #(
    parameter int unsigned DATA_W = misc_v_pkg::DATA_W,
    parameter int unsigned ADDR_W = misc_v_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              ex_fwd_valid_i,
    input  logic              ex_is_load_i,
    input  logic [ADDR_W-1:0] ex_fwd_rd_i,
    input  logic [DATA_W-1:0] ex_fwd_data_i,
    input  logic              mem_fwd_valid_i,
    input  logic [ADDR_W-1:0] mem_fwd_rd_i,
    input  logic [DATA_W-1:0] mem_fwd_data_i,
    output logic [DATA_W-1:0] operand_c_o
);

    import misc_v_pkg::*;

    // Zero register first, then the youngest result (EX), then MEM, then the register file.
    // A load in EX has no data yet, so it must not be forwarded.
    always_comb begin : fwd_select
        operand_c_o = reg_data_i;
        if (addr_i == ADDR_W'(ZERO_REG)) begin
            operand_c_o = '0;
        end else if (ex_fwd_valid_i && !ex_is_load_i && (ex_fwd_rd_i == addr_i)) begin
            operand_c_o = ex_fwd_data_i;
        end else if (mem_fwd_valid_i && (mem_fwd_rd_i == addr_i)) begin
            operand_c_o = mem_fwd_data_i;
        end
    end

endmodule : operand_forward_mux

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: drives register file read addresses, forwards EX/MEM
// results, detects load-use hazards and holds resolved operands in a valid/ready register.
//   CLK, Reset                  : clock, asynchronous active-low reset
//   Dec_*                       : instruction from decode (valid/ready handshake)
//   Reg_address1..3 / Reg_output1..3 : register file read ports
//   Ex_fwd_*, Ex_is_load, Mem_fwd_* : forwarding sources and load-in-EX indication
//   Flush                       : synchronous squash of the operand register
//   Out_*, Ex_ready             : operand register to execute (valid/ready handshake)
//   Stall_count, Clear_count    : saturating stall-cycle counter and its clear
module operand_stage #(
    parameter int unsigned DATA_W = misc_v_pkg::DATA_W,
    parameter int unsigned ADDR_W = misc_v_pkg::REG_ADDR_W,
    parameter int unsigned CTRL_W = misc_v_pkg::CTRL_W,
    parameter int unsigned CNT_W  = misc_v_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              Reset,
    // decode side
    input  logic              Dec_valid,
    output logic              Dec_ready,
    input  logic [ADDR_W-1:0] Dec_rs1,
    input  logic [ADDR_W-1:0] Dec_rs2,
    input  logic [ADDR_W-1:0] Dec_rs3,
    input  logic [2:0]        Dec_use,
    input  logic [ADDR_W-1:0] Dec_rd,
    input  logic              Dec_reg_write,
    input  logic              Dec_is_load,
    input  logic [DATA_W-1:0] Dec_imm,
    input  logic [CTRL_W-1:0] Dec_ctrl,
    // register file
    output logic [ADDR_W-1:0] Reg_address1,
    output logic [ADDR_W-1:0] Reg_address2,
    output logic [ADDR_W-1:0] Reg_address3,
    input  logic [DATA_W-1:0] Reg_output1,
    input  logic [DATA_W-1:0] Reg_output2,
    input  logic [DATA_W-1:0] Reg_output3,
    // forwarding
    input  logic              Ex_fwd_valid,
    input  logic [ADDR_W-1:0] Ex_fwd_rd,
    input  logic [DATA_W-1:0] Ex_fwd_data,
    input  logic              Ex_is_load,
    input  logic              Mem_fwd_valid,
    input  logic [ADDR_W-1:0] Mem_fwd_rd,
    input  logic [DATA_W-1:0] Mem_fwd_data,
    // control
    input  logic              Flush,
    // execute side
    output logic              Out_valid,
    input  logic              Ex_ready,
    output logic [DATA_W-1:0] Out_op1,
    output logic [DATA_W-1:0] Out_op2,
    output logic [DATA_W-1:0] Out_op3,
    output logic [DATA_W-1:0] Out_imm,
    output logic [CTRL_W-1:0] Out_ctrl,
    output logic [ADDR_W-1:0] Out_rd,
    output logic              Out_reg_write,
    output logic              Out_is_load,
    // statistics
    output logic [CNT_W-1:0]  Stall_count,
    input  logic              Clear_count
);

    import misc_v_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    op_state_e         state_q, state_d;
    logic              load_c;
    logic              hazard_c;
    logic              src_hit_c;
    logic              stall_inc_c;

    logic [ADDR_W-1:0] src_addr [NUM_SRC];
    logic [DATA_W-1:0] src_rdata [NUM_SRC];
    logic [DATA_W-1:0] fwd_op_c [NUM_SRC];

    logic [DATA_W-1:0] out_op_q [NUM_SRC];
    logic [DATA_W-1:0] out_imm_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [ADDR_W-1:0] out_rd_q;
    logic              out_reg_write_q;
    logic              out_is_load_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Register file is addressed straight from decode so its data is ready this cycle.
    assign src_addr[0]  = Dec_rs1;
    assign src_addr[1]  = Dec_rs2;
    assign src_addr[2]  = Dec_rs3;
    assign src_rdata[0] = Reg_output1;
    assign src_rdata[1] = Reg_output2;
    assign src_rdata[2] = Reg_output3;

    assign Reg_address1 = Dec_rs1;
    assign Reg_address2 = Dec_rs2;
    assign Reg_address3 = Dec_rs3;

    // One forwarding mux per source operand.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        operand_forward_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_fwd (
            .addr_i          (src_addr[g]),
            .reg_data_i      (src_rdata[g]),
            .ex_fwd_valid_i  (Ex_fwd_valid),
            .ex_is_load_i    (Ex_is_load),
            .ex_fwd_rd_i     (Ex_fwd_rd),
            .ex_fwd_data_i   (Ex_fwd_data),
            .mem_fwd_valid_i (Mem_fwd_valid),
            .mem_fwd_rd_i    (Mem_fwd_rd),
            .mem_fwd_data_i  (Mem_fwd_data),
            .operand_c_o     (fwd_op_c[g])
        );
    end

    // Load-use hazard: a used source needs the result of the load still in EX.
    // Unused sources are forwarded anyway but never stall.
    always_comb begin : hazard_detect
        src_hit_c = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (Dec_use[i] && (src_addr[i] == Ex_fwd_rd)) begin
                src_hit_c = 1'b1;
            end
        end
        hazard_c = Dec_valid && Ex_is_load && (Ex_fwd_rd != ADDR_W'(ZERO_REG)) && src_hit_c;
    end

    assign Dec_ready = !Flush && !hazard_c && ((state_q == ST_EMPTY) || Ex_ready);

    // Occupancy FSM: flush beats accept, accept beats drain.
    always_ff @(posedge CLK or negedge Reset) begin : state_reg
        if (!Reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : state_next
        state_d = state_q;
        load_c  = 1'b0;
        if (Flush) begin
            state_d = ST_EMPTY;
        end else if (Dec_valid && Dec_ready) begin
            state_d = ST_FULL;
            load_c  = 1'b1;
        end else if ((state_q == ST_FULL) && Ex_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Payload only changes on accept, so a held instruction stays stable until taken.
    always_ff @(posedge CLK or negedge Reset) begin : payload_reg
        if (!Reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                out_op_q[i] <= '0;
            end
            out_imm_q       <= '0;
            out_ctrl_q      <= '0;
            out_rd_q        <= '0;
            out_reg_write_q <= 1'b0;
            out_is_load_q   <= 1'b0;
        end else if (load_c) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                out_op_q[i] <= fwd_op_c[i];
            end
            out_imm_q       <= Dec_imm;
            out_ctrl_q      <= Dec_ctrl;
            out_rd_q        <= Dec_rd;
            out_reg_write_q <= Dec_reg_write;
            out_is_load_q   <= Dec_is_load;
        end
    end

    // Stall counter: counts cycles decode is held back for reasons other than a flush.
    assign stall_inc_c = Dec_valid && !Dec_ready && !Flush;

    always_comb begin : stall_next
        stall_cnt_d = stall_cnt_q;
        if (Clear_count) begin
            stall_cnt_d = '0;
        end else if (stall_inc_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin : stall_reg
        if (!Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Out_valid     = (state_q == ST_FULL);
    assign Out_op1       = out_op_q[0];
    assign Out_op2       = out_op_q[1];
    assign Out_op3       = out_op_q[2];
    assign Out_imm       = out_imm_q;
    assign Out_ctrl      = out_ctrl_q;
    assign Out_rd        = out_rd_q;
    assign Out_reg_write = out_reg_write_q;
    assign Out_is_load   = out_is_load_q;
    assign Stall_count   = stall_cnt_q;

endmodule : operand_stage

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: a driver issues directed and random instructions and
// pushes the expected operand-register contents; a monitor pops and compares whenever the
// stage presents a valid output.
module tb_operand_stage;

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] op3;
        logic [15:0] imm;
        logic [7:0]  ctrl;
        logic [2:0]  rd;
        logic        reg_write;
        logic        is_load;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Dec_valid, Dec_ready;
    logic [2:0]  Dec_rs1, Dec_rs2, Dec_rs3, Dec_use, Dec_rd;
    logic        Dec_reg_write, Dec_is_load;
    logic [15:0] Dec_imm;
    logic [7:0]  Dec_ctrl;
    logic [2:0]  Reg_address1, Reg_address2, Reg_address3;
    logic [15:0] Reg_output1, Reg_output2, Reg_output3;
    logic        Ex_fwd_valid, Ex_is_load, Mem_fwd_valid;
    logic [2:0]  Ex_fwd_rd, Mem_fwd_rd;
    logic [15:0] Ex_fwd_data, Mem_fwd_data;
    logic        Flush, Out_valid, Ex_ready;
    logic [15:0] Out_op1, Out_op2, Out_op3, Out_imm;
    logic [7:0]  Out_ctrl;
    logic [2:0]  Out_rd;
    logic        Out_reg_write, Out_is_load;
    logic [15:0] Stall_count;
    logic        Clear_count;

    logic [15:0] rf [8];
    exp_t        sb_q [$];
    exp_t        last_exp;
    bit          m_full;
    int          m_cnt;
    int          n_checks;
    int          n_errors;

    always #5 CLK = ~CLK;

    // Behavioural register file read ports.
    assign Reg_output1 = rf[Reg_address1];
    assign Reg_output2 = rf[Reg_address2];
    assign Reg_output3 = rf[Reg_address3];

    operand_stage dut (
        .CLK(CLK), .Reset(Reset),
        .Dec_valid(Dec_valid), .Dec_ready(Dec_ready),
        .Dec_rs1(Dec_rs1), .Dec_rs2(Dec_rs2), .Dec_rs3(Dec_rs3), .Dec_use(Dec_use),
        .Dec_rd(Dec_rd), .Dec_reg_write(Dec_reg_write), .Dec_is_load(Dec_is_load),
        .Dec_imm(Dec_imm), .Dec_ctrl(Dec_ctrl),
        .Reg_address1(Reg_address1), .Reg_address2(Reg_address2), .Reg_address3(Reg_address3),
        .Reg_output1(Reg_output1), .Reg_output2(Reg_output2), .Reg_output3(Reg_output3),
        .Ex_fwd_valid(Ex_fwd_valid), .Ex_fwd_rd(Ex_fwd_rd), .Ex_fwd_data(Ex_fwd_data),
        .Ex_is_load(Ex_is_load),
        .Mem_fwd_valid(Mem_fwd_valid), .Mem_fwd_rd(Mem_fwd_rd), .Mem_fwd_data(Mem_fwd_data),
        .Flush(Flush), .Out_valid(Out_valid), .Ex_ready(Ex_ready),
        .Out_op1(Out_op1), .Out_op2(Out_op2), .Out_op3(Out_op3), .Out_imm(Out_imm),
        .Out_ctrl(Out_ctrl), .Out_rd(Out_rd), .Out_reg_write(Out_reg_write),
        .Out_is_load(Out_is_load),
        .Stall_count(Stall_count), .Clear_count(Clear_count)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Operand value an instruction should see, from the architectural rules.
    function automatic logic [15:0] fwd_model(logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (Ex_fwd_valid && !Ex_is_load && Ex_fwd_rd == a) return Ex_fwd_data;
        if (Mem_fwd_valid && Mem_fwd_rd == a) return Mem_fwd_data;
        return rf[a];
    endfunction

    function automatic bit reads_reg(logic [2:0] r);
        return (Dec_use[0] && Dec_rs1 == r) || (Dec_use[1] && Dec_rs2 == r) ||
               (Dec_use[2] && Dec_rs3 == r);
    endfunction

    function automatic void cmp_out(exp_t h, string tag);
        check({tag, "_op1"}, 32'(Out_op1), 32'(h.op1));
        check({tag, "_op2"}, 32'(Out_op2), 32'(h.op2));
        check({tag, "_op3"}, 32'(Out_op3), 32'(h.op3));
        check({tag, "_imm"}, 32'(Out_imm), 32'(h.imm));
        check({tag, "_ctrl"}, 32'(Out_ctrl), 32'(h.ctrl));
        check({tag, "_rd"}, 32'(Out_rd), 32'(h.rd));
        check({tag, "_rw"}, 32'(Out_reg_write), 32'(h.reg_write));
        check({tag, "_ld"}, 32'(Out_is_load), 32'(h.is_load));
    endfunction

    task automatic idle();
        Dec_valid = 0; Dec_rs1 = 0; Dec_rs2 = 0; Dec_rs3 = 0; Dec_use = 0; Dec_rd = 0;
        Dec_reg_write = 0; Dec_is_load = 0; Dec_imm = 0; Dec_ctrl = 0;
        Ex_fwd_valid = 0; Ex_fwd_rd = 0; Ex_fwd_data = 0; Ex_is_load = 0;
        Mem_fwd_valid = 0; Mem_fwd_rd = 0; Mem_fwd_data = 0;
        Flush = 0; Ex_ready = 1; Clear_count = 0;
    endtask

    task automatic rand_dec();
        Dec_valid     = ($urandom_range(3) != 0);
        Dec_rs1       = 3'($urandom_range(7));
        Dec_rs2       = 3'($urandom_range(7));
        Dec_rs3       = 3'($urandom_range(7));
        Dec_use       = 3'($urandom_range(7));
        Dec_rd        = 3'($urandom_range(7));
        Dec_reg_write = 1'($urandom_range(1));
        Dec_is_load   = 1'($urandom_range(1));
        Dec_imm       = 16'($urandom);
        Dec_ctrl      = 8'($urandom);
    endtask

    task automatic rand_all();
        rand_dec();
        Ex_fwd_valid  = 1'($urandom_range(1));
        Ex_fwd_rd     = 3'($urandom_range(7));
        Ex_fwd_data   = 16'($urandom);
        Ex_is_load    = ($urandom_range(3) == 0);
        Mem_fwd_valid = 1'($urandom_range(1));
        Mem_fwd_rd    = 3'($urandom_range(7));
        Mem_fwd_data  = 16'($urandom);
        Flush         = ($urandom_range(15) == 0);
        Ex_ready      = ($urandom_range(2) != 0);
        Clear_count   = ($urandom_range(31) == 0);
        if ($urandom_range(7) == 0) rf[$urandom_range(7)] = 16'($urandom);
    endtask

    // One clock: evaluate the model on the current inputs, then advance the edge.
    task automatic step();
        bit   hz, rdy, acc;
        exp_t e;
        #1;
        hz  = Dec_valid && Ex_is_load && (Ex_fwd_rd != 3'd0) && reads_reg(Ex_fwd_rd);
        rdy = !Flush && !hz && (!m_full || Ex_ready);
        acc = Dec_valid && rdy;
        if (Dec_valid) check("dec_ready", 32'(Dec_ready), 32'(rdy));
        check("reg_addr", {23'd0, Reg_address3, Reg_address2, Reg_address1},
              {23'd0, Dec_rs3, Dec_rs2, Dec_rs1});
        if (acc) begin
            e = '{op1: fwd_model(Dec_rs1), op2: fwd_model(Dec_rs2), op3: fwd_model(Dec_rs3),
                  imm: Dec_imm, ctrl: Dec_ctrl, rd: Dec_rd, reg_write: Dec_reg_write,
                  is_load: Dec_is_load};
            sb_q.push_back(e);
            last_exp = e;
        end
        if (Clear_count) m_cnt = 0;
        else if (Dec_valid && !rdy && !Flush && m_cnt < 65535) m_cnt++;
        if (Flush) m_full = 0;
        else if (acc) m_full = 1;
        else if (m_full && Ex_ready) m_full = 0;
        @(posedge CLK);
        #1;
        check("stall_count", 32'(Stall_count), 32'(m_cnt));
    endtask

    // Monitor: pops one expectation per presented instruction, rechecks while it is held.
    initial begin : monitor
        bit   have_head;
        exp_t head;
        have_head = 0;
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                have_head = 0;
            end else if (Out_valid) begin
                if (!have_head) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", 32'(Out_valid), 32'd0);
                    end else begin
                        head = sb_q.pop_front();
                        have_head = 1;
                        cmp_out(head, "out");
                    end
                end else begin
                    cmp_out(head, "hold");
                end
                if (Ex_ready || Flush) have_head = 0;
            end
        end
    end

    initial begin : driver
        n_checks = 0; n_errors = 0; m_full = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        rf[0] = 16'hBEEF;
        idle();
        Reset = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(Out_valid), 32'd0);
        check("rst_out_op1", 32'(Out_op1), 32'd0);
        check("rst_stall", 32'(Stall_count), 32'd0);
        Reset = 1;

        // Plain register read.
        rf[3] = 16'h1234;
        Dec_valid = 1; Dec_rs1 = 3; Dec_rs2 = 1; Dec_rs3 = 4; Dec_use = 3'b111;
        Dec_imm = 16'h00AA; Dec_ctrl = 8'h5C; Dec_rd = 6; Dec_reg_write = 1;
        step();
        check("basic_valid", 32'(Out_valid), 32'd1);
        check("basic_op1", 32'(Out_op1), 32'h1234);

        // EX beats MEM on the same register; r0 reads zero.
        Dec_rs1 = 0; Dec_rs2 = 5; Dec_rs3 = 7;
        Ex_fwd_valid = 1; Ex_fwd_rd = 5; Ex_fwd_data = 16'hAAAA;
        Mem_fwd_valid = 1; Mem_fwd_rd = 5; Mem_fwd_data = 16'h5555;
        step();
        check("fwd_ex_op2", 32'(Out_op2), 32'hAAAA);
        check("fwd_r0_op1", 32'(Out_op1), 32'h0000);

        // Hold while FULL, accumulate a stall, then reset asynchronously.
        idle(); Ex_ready = 0; Dec_valid = 1;
        step();
        check("pre_rst_stall", 32'(Stall_count), 32'd1);
        #2; Reset = 0; #1;
        check("async_rst_valid", 32'(Out_valid), 32'd0);
        check("async_rst_ops", {16'd0, Out_op1 | Out_op2 | Out_op3}, 32'd0);
        check("async_rst_stall", 32'(Stall_count), 32'd0);
        sb_q.delete(); m_full = 0; m_cnt = 0;
        @(posedge CLK); #1; Reset = 1;

        // Load-use hazard on a used source: bubble and one stall cycle.
        idle(); Dec_valid = 1; Dec_rs1 = 2; Dec_rs2 = 1; Dec_rs3 = 3; Dec_use = 3'b001;
        Ex_is_load = 1; Ex_fwd_valid = 1; Ex_fwd_rd = 2; Ex_fwd_data = 16'h7777;
        step();
        check("hazard_bubble", 32'(Out_valid), 32'd0);
        check("hazard_stall", 32'(Stall_count), 32'd1);
        Dec_use = 3'b000;
        step();
        check("unused_accept", 32'(Out_valid), 32'd1);

        // Take that one, accept a fresh one, then hold it for 3 cycles of noise.
        idle(); Dec_valid = 1; Dec_rs1 = 4; Dec_imm = 16'hC0DE; Dec_ctrl = 8'h3A;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_all(); Ex_ready = 0; Flush = 0; Clear_count = 0;
            step();
        end
        check("hold_op1", 32'(Out_op1), 32'(last_exp.op1));
        check("hold_imm", 32'(Out_imm), 32'(last_exp.imm));
        check("hold_valid", 32'(Out_valid), 32'd1);
        idle(); Ex_ready = 0; Flush = 1;
        step();
        check("flush_valid", 32'(Out_valid), 32'd0);

        // Saturate the stall counter, then clear it while stalls continue.
        idle(); Dec_valid = 1; Dec_rs1 = 2; Dec_use = 3'b001; Ex_is_load = 1; Ex_fwd_rd = 2;
        for (int i = 0; i < 65536; i++) step();
        check("stall_sat", 32'(Stall_count), 32'hFFFF);
        Clear_count = 1;
        step();
        check("stall_clear", 32'(Stall_count), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_all();
            step();
        end

        idle(); Ex_ready = 1;
        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_operand_stage
